pipelined_adder: RTL and testbench

//   Parametrised, pipelined add/subtract unit with a valid/ready handshake on both sides.
//   The carry chain is split into CHUNK-bit slices, with one register stage per slice.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/adder_slice_stage.sv | 107 ++++++++++
 rtl/pipelined_adder.sv | 119 +++++++++++
 tb/tb_pipelined_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Shared types and elaboration-time helpers for the pipelined add/subtract
//   unit.
//   - op_e      : operation select (add / subtract)
//   - cfg_ok()  : true when WIDTH is a positive multiple of CHUNK
//   - n_stages(): number of pipeline stages for a WIDTH/CHUNK pair
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  function automatic int n_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_slice_stage.sv
// ---------------------------------------------------------------------------
// adder_slice_stage
//   One pipeline stage of the pipelined adder. Resolves the CHUNK-bit slice
//   number IDX using the carry handed over by the previous stage, then
//   registers the beat.
//
//   Payload layout (LSB first), input side:
//     [RES_IN-1:0]                    result bits already resolved
//     [RES_IN +: OPR_IN]              remaining B bits (already inverted for sub)
//     [RES_IN+OPR_IN +: OPR_IN]       remaining A bits
//   Output side is the same layout with one slice moved from the operand
//   fields into the result field, so the payload narrows by CHUNK bits per
//   stage and the last stage carries exactly the WIDTH-bit result.
//
// Ports
//   clk, rst     clock, async active-high reset
//   load_i       upstream beat transfers into this stage this cycle
//   adv_i        this stage's beat moves downstream this cycle
//   payload_i    upstream payload (PI_W bits)
//   carry_i      carry into this slice
//   op_i         operation of the upstream beat
//   valid_o      stage holds a beat
//   payload_o    registered payload (PO_W bits)
//   carry_o      registered carry out of this slice
//   op_o         registered operation
// ---------------------------------------------------------------------------
module adder_slice_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0,
  localparam int RES_IN  = IDX * CHUNK,
  localparam int OPR_IN  = WIDTH - RES_IN,
  localparam int RES_OUT = RES_IN + CHUNK,
  localparam int OPR_OUT = OPR_IN - CHUNK,
  localparam int PI_W    = 2 * OPR_IN + RES_IN,
  localparam int PO_W    = 2 * OPR_OUT + RES_OUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            adv_i,
  input  logic [PI_W-1:0] payload_i,
  input  logic            carry_i,
  input  op_e             op_i,
  output logic            valid_o,
  output logic [PO_W-1:0] payload_o,
  output logic            carry_o,
  output op_e             op_o
);

  logic [CHUNK-1:0] a_lo;
  logic [CHUNK-1:0] b_lo;
  logic [CHUNK:0]   slice_sum;
  logic [PO_W-1:0]  payload_d;
  logic [PO_W-1:0]  payload_q;
  logic             valid_d;
  logic             valid_q;
  logic             carry_q;
  op_e              op_q;

  assign a_lo      = payload_i[RES_IN + OPR_IN +: CHUNK];
  assign b_lo      = payload_i[RES_IN +: CHUNK];
  assign slice_sum = {1'b0, a_lo} + {1'b0, b_lo} + {{CHUNK{1'b0}}, carry_i};

  // Rebuild the payload bit by bit; loops with zero trip count cover the
  // first stage (no resolved bits yet) and the last (no operand bits left).
  always_comb begin
    payload_d = '0;
    for (int i = 0; i < OPR_OUT; i++) begin
      payload_d[RES_OUT + OPR_OUT + i] = payload_i[RES_IN + OPR_IN + CHUNK + i];
      payload_d[RES_OUT + i]           = payload_i[RES_IN + CHUNK + i];
    end
    for (int i = 0; i < CHUNK; i++) begin
      payload_d[RES_IN + i] = slice_sum[i];
    end
    for (int i = 0; i < RES_IN; i++) begin
      payload_d[i] = payload_i[i];
    end
  end

  // A load only happens when this stage is empty or draining, so load wins.
  assign valid_d = load_i | (valid_q & ~adv_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      carry_q   <= 1'b0;
      op_q      <= OP_ADD;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        payload_q <= payload_d;
        carry_q   <= slice_sum[CHUNK];
        op_q      <= op_i;
      end
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;
  assign carry_o   = carry_q;
  assign op_o      = op_q;

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   Pipelined add/subtract unit, one register stage per CHUNK-bit slice of
//   the carry chain (STAGES = WIDTH/CHUNK). Latency STAGES, 1 beat/cycle.
//   Subtraction is a + ~b + ~cin; the final carry is inverted into a borrow.
//
//   Handshake: a beat transfers on a side when valid & ready are both high
//   in the same cycle. Once out_valid rises it stays high with stable
//   sum/cout until out_ready accepts it. in_ready may depend combinationally
//   on out_ready through the stage advance chain.
//
// Ports
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   input handshake
//   a, b, cin, op_sub   operands, carry/borrow in, 0=add 1=sub
//   out_valid/out_ready output handshake
//   sum, cout           result mod 2^WIDTH, carry-out (add) / borrow-out (sub)
//   busy                any stage holds a beat
// ---------------------------------------------------------------------------
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int STAGES = n_stages(WIDTH, CHUNK);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $fatal(1, "pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end

  op_e              op_in;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             in_fire;
  logic [STAGES-1:0] valid;

  assign op_in   = op_e'(op_sub);
  assign b_eff   = (op_in == OP_SUB) ? ~b : b;
  assign cin_eff = (op_in == OP_SUB) ? ~cin : cin;
  assign in_fire = in_valid & in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int PI_W = 2 * (WIDTH - k * CHUNK) + k * CHUNK;
    localparam int PO_W = 2 * (WIDTH - (k + 1) * CHUNK) + (k + 1) * CHUNK;

    logic [PI_W-1:0] pin;
    logic [PO_W-1:0] pout;
    logic            carry_in_s;
    op_e             op_in_s;
    logic            load_s;
    logic            valid_s;
    logic            adv_s;
    logic            carry_s;
    op_e             op_s;

    if (k == 0) begin : g_first
      assign pin        = {a, b_eff};
      assign carry_in_s = cin_eff;
      assign op_in_s    = op_in;
      assign load_s     = in_fire;
    end else begin : g_next
      assign pin        = g_stage[k-1].pout;
      assign carry_in_s = g_stage[k-1].carry_s;
      assign op_in_s    = g_stage[k-1].op_s;
      assign load_s     = g_stage[k-1].adv_s;
    end

    // A stage moves on when it is full and the next one is empty or moving.
    if (k == STAGES - 1) begin : g_last_adv
      assign adv_s = valid_s & out_ready;
    end else begin : g_mid_adv
      assign adv_s = valid_s & (~g_stage[k+1].valid_s | g_stage[k+1].adv_s);
    end

    adder_slice_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load_s),
      .adv_i     (adv_s),
      .payload_i (pin),
      .carry_i   (carry_in_s),
      .op_i      (op_in_s),
      .valid_o   (valid_s),
      .payload_o (pout),
      .carry_o   (carry_s),
      .op_o      (op_s)
    );

    assign valid[k] = valid_s;
  end

  assign in_ready  = ~g_stage[0].valid_s | g_stage[0].adv_s;
  assign out_valid = g_stage[STAGES-1].valid_s;
  assign sum       = g_stage[STAGES-1].pout;
  // For subtraction a carry out of a + ~b + ~cin means "no borrow".
  assign cout      = g_stage[STAGES-1].carry_s ^ (g_stage[STAGES-1].op_s == OP_SUB);
  assign busy      = |valid;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [WIDTH:0] exp_q[$];
  int             cyc_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             cyc      = 0;
  int             in_cnt   = 0;
  int             out_cnt  = 0;
  bit             lat_chk  = 0;
  bit             hold_pending = 0;
  bit             last_in_fire = 0;
  logic [WIDTH:0] last_out = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c, input logic s);
    logic [WIDTH:0] r;
    logic [WIDTH:0] sub_amt;
    if (!s) begin
      r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    end else begin
      sub_amt        = {1'b0, y} + {{WIDTH{1'b0}}, c};
      r[WIDTH-1:0]   = x - y - {{(WIDTH-1){1'b0}}, c};
      r[WIDTH]       = ({1'b0, x} < sub_amt);
    end
    return r;
  endfunction

  // Observes the handshakes at the falling edge, where inputs and outputs
  // hold the values the next rising edge will act on.
  task automatic monitor();
    logic [WIDTH:0] e;
    int             t;
    cyc++;
    last_in_fire = in_valid && in_ready;
    if (hold_pending) check("out_hold_valid", {31'b0, out_valid}, 32'd1);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        t = cyc_q.pop_front();
        check("result", {15'b0, cout, sum}, {15'b0, e});
        if (lat_chk) check("latency", cyc - t, STAGES);
        last_out = {cout, sum};
        out_cnt++;
      end
    end
    hold_pending = out_valid && !out_ready;
    if (last_in_fire) begin
      exp_q.push_back(ref_model(a, b, cin, op_sub));
      cyc_q.push_back(cyc);
      in_cnt++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic c, input logic s);
    int guard;
    in_valid = 1'b1; a = x; b = y; cin = c; op_sub = s;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!last_in_fire && guard < 200);
    if (!last_in_fire) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
  endtask

  task automatic drain();
    int guard;
    idle_inputs();
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      step();
      guard++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    exp_q.delete();
    cyc_q.delete();
    hold_pending = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int accepted;
    int j;
    int guard;
    rst = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    #1;
    apply_reset();

    // reset state
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum",       {16'b0, sum},       32'd0);
    check("rst_cout",      {31'b0, cout},      32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);

    // 1: carry ripples through every slice
    lat_chk = 1;
    send_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain();
    check("t1_result", {15'b0, last_out}, 32'h1_0000);
    step();
    check("t1_out_valid_one_cycle", {31'b0, out_valid}, 32'd0);
    check("t1_busy_idle", {31'b0, busy}, 32'd0);

    // 2: subtraction with and without borrow
    send_beat(16'h0003, 16'h0005, 1'b0, 1'b1);
    drain();
    check("t2a_result", {15'b0, last_out}, {15'b0, 1'b1, 16'hFFFE});
    send_beat(16'h1234, 16'h0234, 1'b1, 1'b1);
    drain();
    check("t2b_result", {15'b0, last_out}, {15'b0, 1'b0, 16'h0FFF});

    // 3: back-to-back stream at full rate
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = WIDTH'(i); b = WIDTH'(i); cin = 1'b1; op_sub = 1'b0;
      check("t3_in_ready", {31'b0, in_ready}, 32'd1);
      step();
      check("t3_accept", {31'b0, last_in_fire}, 32'd1);
    end
    drain();
    check("t3_last", {15'b0, last_out}, 32'd15);

    // 4: backpressure fills the pipeline
    lat_chk = 0;
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = WIDTH'(16'h0100 + accepted); b = WIDTH'(16'h0011);
      cin = 1'b0; op_sub = accepted[0];
      step();
      if (last_in_fire) accepted++;
      if (exp_q.size() > 0 && out_valid)
        check("t4_hold_sum", {15'b0, cout, sum}, {15'b0, exp_q[0]});
    end
    check("t4_accepted", accepted, STAGES);
    check("t4_in_ready_full", {31'b0, in_ready}, 32'd0);
    check("t4_busy", {31'b0, busy}, 32'd1);
    out_ready = 1'b1;
    j = accepted;
    guard = 0;
    while (j < 6 && guard < 100) begin
      in_valid = 1'b1; a = WIDTH'(16'h0100 + j); b = WIDTH'(16'h0011); cin = 1'b0; op_sub = j[0];
      step();
      if (last_in_fire) j++;
      guard++;
    end
    check("t4_total_accepted", j, 32'd6);
    drain();

    // 5: async reset with beats in flight
    lat_chk = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = WIDTH'(16'hA000 + i); b = 16'h0F0F; cin = 1'b0; op_sub = 1'b0;
      step();
    end
    idle_inputs();
    check("t5_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_out_valid_async", {31'b0, out_valid}, 32'd0);
    check("t5_busy_async", {31'b0, busy}, 32'd0);
    exp_q.delete();
    cyc_q.delete();
    hold_pending = 0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_no_stale", {31'b0, out_valid}, 32'd0);
    end
    send_beat(16'h7FFF, 16'h0001, 1'b1, 1'b0);
    idle_inputs();
    drain();
    check("t5_new_result", {15'b0, last_out}, 32'h0_8001);

    // 6: random traffic with random backpressure
    lat_chk = 0;
    in_cnt  = 0;
    out_cnt = 0;
    guard   = 0;
    while (in_cnt < 10000 && guard < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = WIDTH'($urandom_range(0, 65535));
      b         = WIDTH'($urandom_range(0, 65535));
      cin       = 1'($urandom_range(0, 1));
      op_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      guard++;
    end
    check("t6_in_count", in_cnt, 32'd10000);
    drain();
    check("t6_out_count", out_cnt, in_cnt);
    step();
    check("t6_busy_idle", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
